// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the programmable timer/counter
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/timer_counter_prescaler.sv
// rtl/timer_counter_prescaler.sv - tick every presc+1 enabled cycles
module tick_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] presc,
  output logic          tick
);

  logic [PW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit = (r_cnt == presc);
  // A clear wins over the tick so load/start/stop never coincide with a count step.
  assign tick  = en && !clr && w_hit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_hit ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable up/down timer with wrap/sat/one-shot modes
module timer_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PW-1:0]    presc,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  logic             w_tick;
  logic             w_presc_en;
  logic             w_presc_clr;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_rest;
  logic             w_at_t;
  logic             w_beyond;
  logic [WIDTH-1:0] w_next;
  logic             w_next_tc;
  mode_t            w_mode;

  assign w_presc_en  = en && (r_state == RUN);
  assign w_presc_clr = load || stop || start;

  tick_prescaler #(.PW(PW)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (w_presc_en),
    .clr   (w_presc_clr),
    .presc (presc),
    .tick  (w_tick)
  );

  assign w_mode   = mode_t'(mode);
  assign w_term   = dir ? '0 : limit;
  assign w_rest   = dir ? limit : '0;
  assign w_at_t   = (r_count == w_term);
  assign w_beyond = !dir && (r_count > limit);

  // Terminal check precedes the +/-1, so the count never steps past T.
  always_comb begin
    w_next    = r_count;
    w_next_tc = 1'b0;
    if (!(w_at_t || w_beyond)) begin
      w_next    = dir ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
      w_next_tc = (w_next == w_term);
    end else begin
      case (w_mode)
        SAT, ONESHOT: w_next = w_term;
        default:      w_next = w_rest;
      endcase
      w_next_tc = (w_next == w_term) && !((w_mode == SAT) && w_at_t);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
      end else if (start) begin
        r_state <= RUN;
        r_done  <= 1'b0;
        if (r_state == DONE) r_count <= w_rest;
      end else if (r_state == RUN && w_tick) begin
        r_count <= w_next;
        r_tc    <= w_next_tc;
        if (w_next_tc && w_mode == ONESHOT) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end
      if (load) r_count <= load_val;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign running = (r_state == RUN);
  assign done    = r_done;

endmodule

// File: doc/timer_counter.md
# timer_counter

Programmable timer/counter for the UTILS sector, the parametrised successor of the fixed-modulus generic counter. Adds runtime limit, up/down direction, wrap/saturate/one-shot modes, clock prescaler, parallel load and a terminal-count pulse. Timing sources, baud and tick generators and watchdogs elsewhere in MARVIN instantiate it.

## Interface
- WIDTH, 16: counter width in bits.
- PW, 8: prescaler register width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low freezes the prescaler and ticks.
- start  input  1  enter RUN.
- stop  input  1  enter IDLE.
- load  input  1  parallel load of count.
- load_val  input  WIDTH  load value.
- dir  input  1  0 = up, 1 = down.
- mode  input  2  counting mode (mode_t).
- limit  input  WIDTH  terminal value when up; reload value when down.
- presc  input  PW  a tick every presc+1 enabled cycles.
- count  output  WIDTH  current count.
- tc  output  1  terminal-count pulse, one cycle.
- running  output  1  state == RUN.
- done  output  1  one-shot completed; held until start or rst.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: count = 0, tc = 0, running = 0, done = 0, prescaler = 0.
- Terminal value T = limit when up, 0 when down. Restart value R = 0 when up, limit when down.
- Tick: only in RUN with en = 1 and prescaler == presc. On a tick the prescaler clears; otherwise it increments.
- On a tick, next count:
  - Count not yet at T: count ± 1.
  - Count at T, or beyond T (up with count > limit): WRAP gives R. SAT holds T (clamps to limit if beyond). ONESHOT holds T.
- tc: registered, asserted on the same edge as the count update, on every tick whose new count equals T.
  - Exception in SAT: no tc when the old count was already T.
  - Wrapping from beyond the limit gives no tc unless R equals T.
- ONESHOT: the tick that produces tc also moves RUN to DONE. done = 1 and running = 0 from that edge.
- Control priority per edge: rst > stop > start; load applies independently of the state controls.
- load: count <= load_val. Prescaler clears. No tc that cycle, and no tick is applied.
- stop: state becomes IDLE. Count is held and the prescaler clears. stop overrides start.
- start:
  - From IDLE: state becomes RUN and the prescaler clears.
  - From DONE: state becomes RUN, done clears, and count reloads to R unless load is also asserted.
  - From RUN: the prescaler clears; count is unchanged.
- Mode 2'b11 is reserved and behaves as WRAP.
- dir, mode, limit and presc may change at any time. They take effect from the next edge; T and R are recomputed combinationally.
- limit = 0:
  - Up/WRAP: count stays 0 and tc pulses on every tick.
  - Down: the count runs to 0 and then wraps to 0.
- Arithmetic is modulo 2^WIDTH internally, but wrap below 0 or above limit never occurs, because the terminal check precedes ±1.

## Timing
- presc = 0 with start asserted at edge k: running = 1 after edge k. First count change at edge k+1, then one per cycle.
- Tick period is presc+1 cycles of en = 1. Cycles with en = 0 do not advance the prescaler.
- WRAP tc period = (limit+1)·(presc+1) enabled cycles.
- tc, done and count are all registered. There is no combinational path from inputs to outputs.
- rst mid-run: all outputs return to their reset values at that edge, regardless of other inputs.

## Structure
- Package counter_pkg holds:
  - mode_t enum: WRAP = 2'b00, SAT = 2'b01, ONESHOT = 2'b10, RSVD = 2'b11.
  - state_t enum: IDLE, RUN, DONE.
- Sub-module tick_prescaler (parameter PW; ports clk, rst, en, clr, presc, tick) generates the tick.
- timer_counter contains the FSM, the count register and tc/done generation.

## Test plan
- Reset, then WRAP, up, limit = 3, presc = 0, start pulse → count 0,1,2,3,0,1…; tc high exactly when count shows 3.
- ONESHOT, down, limit = 5, load_val = 2 with load, then start → count 2,1,0. tc and done rise on the edge count becomes 0; running drops. A further start reloads count to 5.
- SAT, up, limit = 4, presc = 2 → count advances every 3 cycles and sticks at 4; a single tc pulse; running stays 1.
- en toggled low for 4 cycles mid-period with presc = 3 → tick delayed by exactly 4 cycles. Simultaneous start+stop → IDLE. Simultaneous load+tick → count = load_val, no tc.
- WRAP, up, count = 10, then limit changed to 6 → next tick count = 0, no tc. limit = 0 → tc every tick, count stays 0.
- rst asserted mid-RUN together with load and start → count = 0, tc = 0, running = 0, done = 0 on that edge.
